// File: rtl/demux_2s_buf_if.sv
// rtl/demux_2s_buf_if.sv - producer/consumer bus bundle for the registered 1-to-4 demux
interface demux_2s_buf_if #(
    parameter int w  = 4,
    parameter int cw = 8
);
    logic [w-1:0]  d;
    logic [1:0]    s;
    logic          in_valid;
    logic          in_ready;
    logic [w-1:0]  o0;
    logic [w-1:0]  o1;
    logic [w-1:0]  o2;
    logic [w-1:0]  o3;
    logic [3:0]    o_valid;
    logic [3:0]    o_ready;
    logic [cw-1:0] acc_cnt;

    modport slave (
        input  d, s, in_valid, o_ready,
        output in_ready, o0, o1, o2, o3, o_valid, acc_cnt
    );

    modport master (
        output d, s, in_valid, o_ready,
        input  in_ready, o0, o1, o2, o3, o_valid, acc_cnt
    );
endinterface

// File: rtl/demux_2s_buf.sv
// rtl/demux_2s_buf.sv - registered 1-to-4 demux with one-entry buffer per channel
module demux_2s_buf #(
    parameter int w  = 4,
    parameter int cw = 8
) (
    input  logic           clk,
    input  logic           rst_b,
    demux_2s_buf_if.slave  bus
);
    logic [w-1:0]  data_q [4];
    logic [w-1:0]  data_d [4];
    logic [3:0]    valid_q;
    logic [3:0]    valid_d;
    logic [cw-1:0] cnt_q;
    logic [cw-1:0] cnt_d;
    logic [3:0]    sel_oh;
    logic          accept;

    assign sel_oh = 4'b0001 << bus.s;

    // A full channel still accepts when its consumer drains it in the same cycle.
    assign bus.in_ready = !valid_q[bus.s] || bus.o_ready[bus.s];
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
        end
        for (int k = 0; k < 4; k++) begin
            if (valid_q[k] && bus.o_ready[k]) begin
                valid_d[k] = 1'b0;
            end
            // Load overrides the drain so a refill produces no bubble.
            if (accept && sel_oh[k]) begin
                data_d[k]  = bus.d;
                valid_d[k] = 1'b1;
            end
        end
        if (accept) begin
            cnt_d = cnt_q + cw'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= 4'b0000;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.o0      = data_q[0];
    assign bus.o1      = data_q[1];
    assign bus.o2      = data_q[2];
    assign bus.o3      = data_q[3];
    assign bus.o_valid = valid_q;
    assign bus.acc_cnt = cnt_q;
endmodule
